// File: rtl/ahb_master_ctrl.sv
// AHB-Lite single-transfer initiator: a valid/ready command stream feeds a two-stage
// address/data pipeline, and each completed transfer returns one registered response.
module ahb_master_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [1:0]        htrans,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic              a_valid_reg;
    logic              a_write_reg;
    logic [ADDR_W-1:0] a_addr_reg;
    logic [DATA_W-1:0] a_wdata_reg;
    logic              d_valid_reg;
    logic              d_write_reg;
    logic [DATA_W-1:0] d_wdata_reg;
    logic              err_hold_reg;
    logic [ADDR_W-1:0] haddr_last_reg;
    logic              hwrite_last_reg;
    logic [DATA_W-1:0] hwdata_last_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;

    logic issue;
    logic accept;
    logic a_adv;
    logic d_done;

    // While an ERROR is being signalled the pending address phase is parked as IDLE.
    assign issue     = a_valid_reg && !err_hold_reg;
    assign cmd_ready = !a_valid_reg || (hready && !err_hold_reg);
    assign accept    = cmd_valid && cmd_ready;
    assign a_adv     = hready && issue;
    assign d_done    = hready && d_valid_reg;

    assign htrans = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr  = issue ? a_addr_reg : haddr_last_reg;
    assign hwrite = issue ? a_write_reg : hwrite_last_reg;
    assign hwdata = (d_valid_reg && d_write_reg) ? d_wdata_reg : hwdata_last_reg;
    assign hsize  = 3'b000;
    assign hburst = 3'b000;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            a_valid_reg     <= 1'b0;
            a_write_reg     <= 1'b0;
            a_addr_reg      <= '0;
            a_wdata_reg     <= '0;
            d_valid_reg     <= 1'b0;
            d_write_reg     <= 1'b0;
            d_wdata_reg     <= '0;
            err_hold_reg    <= 1'b0;
            haddr_last_reg  <= '0;
            hwrite_last_reg <= 1'b0;
            hwdata_last_reg <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
        end else begin
            haddr_last_reg  <= haddr;
            hwrite_last_reg <= hwrite;
            hwdata_last_reg <= hwdata;

            if (accept) begin
                a_valid_reg <= 1'b1;
                a_write_reg <= cmd_write;
                a_addr_reg  <= cmd_addr;
                a_wdata_reg <= cmd_wdata;
            end else if (a_adv) begin
                a_valid_reg <= 1'b0;
            end

            // a_adv implies hready, so the previous data phase retires on the same edge.
            if (a_adv) begin
                d_valid_reg <= 1'b1;
                d_write_reg <= a_write_reg;
                d_wdata_reg <= a_wdata_reg;
            end else if (d_done) begin
                d_valid_reg <= 1'b0;
            end

            if (hready) begin
                err_hold_reg <= 1'b0;
            end else if (d_valid_reg && hresp) begin
                err_hold_reg <= 1'b1;
            end

            rsp_valid_reg <= d_done;
            rsp_err_reg   <= d_done && hresp;
            rsp_rdata_reg <= (d_done && !d_write_reg) ? hrdata : '0;
        end
    end
endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Directed bench for ahb_master_ctrl: bus-side checks inline, responses checked by a
// scoreboard monitor against expectations queued when each command is accepted.
module tb_ahb_master_ctrl;
    logic       hclk = 1'b0;
    logic       hreset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [1:0] htrans;
    logic [7:0] haddr;
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [7:0] hwdata;
    logic       hready;
    logic       hresp;
    logic [7:0] hrdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t exp_item;
    int   total = 0;
    int   bad   = 0;

    ahb_master_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hwdata    (hwdata),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 hclk = ~hclk;

    // Response monitor: every rsp_valid pulse must match the oldest queued expectation.
    always @(negedge hclk) begin
        if (rsp_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b with nothing pending", rsp_rdata, rsp_err);
            end else begin
                exp_item = exp_q.pop_front();
                if (rsp_rdata !== exp_item.rdata || rsp_err !== exp_item.err) begin
                    bad++;
                    $display("FAIL rsp: got rdata=%h err=%b expected rdata=%h err=%b",
                             rsp_rdata, rsp_err, exp_item.rdata, exp_item.err);
                end else begin
                    $display("rsp ok: rdata=%h err=%b", rsp_rdata, rsp_err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic mid();
        @(negedge hclk);
    endtask

    task automatic cmd(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        if (v) $display("cmd: write=%b addr=%h wdata=%h", w, a, d);
    endtask

    task automatic push(input logic [7:0] rdata, input logic err);
        exp_q.push_back({rdata, err});
    endtask

    task automatic check_reset_outputs(input string pre);
        chk({pre, "_htrans"},    32'(htrans),    32'h0);
        chk({pre, "_haddr"},     32'(haddr),     32'h0);
        chk({pre, "_hwrite"},    32'(hwrite),    32'h0);
        chk({pre, "_hwdata"},    32'(hwdata),    32'h0);
        chk({pre, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({pre, "_rsp_rdata"}, 32'(rsp_rdata), 32'h0);
        chk({pre, "_rsp_err"},   32'(rsp_err),   32'h0);
        chk({pre, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    endtask

    task automatic single_write(input string pre);
        cmd(1'b1, 1'b1, 8'h00, 8'hA5);
        push(8'h00, 1'b0);
        mid();
        chk({pre, "_c0_ready"},  32'(cmd_ready), 32'h1);
        chk({pre, "_c0_htrans"}, 32'(htrans),    32'h0);
        tick();
        cmd(1'b0, 1'b0, 8'h00, 8'h00);
        mid();
        chk({pre, "_c1_htrans"}, 32'(htrans), 32'h2);
        chk({pre, "_c1_haddr"},  32'(haddr),  32'h00);
        chk({pre, "_c1_hwrite"}, 32'(hwrite), 32'h1);
        chk({pre, "_c1_hsize"},  32'(hsize),  32'h0);
        chk({pre, "_c1_hburst"}, 32'(hburst), 32'h0);
        tick();
        mid();
        chk({pre, "_c2_hwdata"}, 32'(hwdata),    32'hA5);
        chk({pre, "_c2_htrans"}, 32'(htrans),    32'h0);
        chk({pre, "_c2_rspv"},   32'(rsp_valid), 32'h0);
        tick();
        mid();
        chk({pre, "_c3_rspv"}, 32'(rsp_valid), 32'h1);
        tick();
        mid();
        chk({pre, "_c4_rspv"}, 32'(rsp_valid), 32'h0);
        tick();
    endtask

    initial begin
        hreset_n = 1'b0;
        hready   = 1'b1;
        hresp    = 1'b0;
        hrdata   = 8'hEE;
        cmd(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        mid();
        check_reset_outputs("reset");
        tick();
        hreset_n = 1'b1;

        // Single write
        single_write("t1");

        // Back-to-back writes
        cmd(1'b1, 1'b1, 8'h00, 8'h11); push(8'h00, 1'b0);
        mid();
        chk("t2_c0_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd(1'b1, 1'b1, 8'h01, 8'h22); push(8'h00, 1'b0);
        mid();
        chk("t2_c1_htrans", 32'(htrans), 32'h2);
        chk("t2_c1_haddr",  32'(haddr),  32'h00);
        tick();
        cmd(1'b1, 1'b1, 8'h02, 8'h13); push(8'h00, 1'b0);
        mid();
        chk("t2_c2_htrans", 32'(htrans), 32'h2);
        chk("t2_c2_haddr",  32'(haddr),  32'h01);
        chk("t2_c2_hwdata", 32'(hwdata), 32'h11);
        tick();
        cmd(1'b0, 1'b0, 8'h00, 8'h00);
        mid();
        chk("t2_c3_htrans", 32'(htrans),    32'h2);
        chk("t2_c3_haddr",  32'(haddr),     32'h02);
        chk("t2_c3_hwdata", 32'(hwdata),    32'h22);
        chk("t2_c3_rspv",   32'(rsp_valid), 32'h1);
        tick();
        mid();
        chk("t2_c4_htrans", 32'(htrans),    32'h0);
        chk("t2_c4_hwdata", 32'(hwdata),    32'h13);
        chk("t2_c4_rspv",   32'(rsp_valid), 32'h1);
        tick();
        mid();
        chk("t2_c5_rspv", 32'(rsp_valid), 32'h1);
        tick();
        mid();
        chk("t2_c6_rspv", 32'(rsp_valid), 32'h0);
        tick();

        // Read with two wait states, second command queued, third held off
        cmd(1'b1, 1'b0, 8'h01, 8'h00); push(8'h5C, 1'b0);
        tick();
        cmd(1'b1, 1'b1, 8'h03, 8'h77); push(8'h00, 1'b0);
        mid();
        chk("t3_c1_htrans", 32'(htrans),    32'h2);
        chk("t3_c1_haddr",  32'(haddr),     32'h01);
        chk("t3_c1_hwrite", 32'(hwrite),    32'h0);
        chk("t3_c1_ready",  32'(cmd_ready), 32'h1);
        tick();
        cmd(1'b1, 1'b1, 8'h04, 8'h88);
        hready = 1'b0;
        hrdata = 8'h33;
        mid();
        chk("t3_c2_htrans", 32'(htrans),    32'h2);
        chk("t3_c2_haddr",  32'(haddr),     32'h03);
        chk("t3_c2_ready",  32'(cmd_ready), 32'h0);
        tick();
        mid();
        chk("t3_c3_htrans", 32'(htrans),    32'h2);
        chk("t3_c3_haddr",  32'(haddr),     32'h03);
        chk("t3_c3_ready",  32'(cmd_ready), 32'h0);
        chk("t3_c3_rspv",   32'(rsp_valid), 32'h0);
        tick();
        hready = 1'b1;
        hrdata = 8'h5C;
        push(8'h00, 1'b0);
        mid();
        chk("t3_c4_ready", 32'(cmd_ready), 32'h1);
        chk("t3_c4_rspv",  32'(rsp_valid), 32'h0);
        tick();
        cmd(1'b0, 1'b0, 8'h00, 8'h00);
        hrdata = 8'hEE;
        mid();
        chk("t3_c5_rspv",   32'(rsp_valid), 32'h1);
        chk("t3_c5_haddr",  32'(haddr),     32'h04);
        chk("t3_c5_htrans", 32'(htrans),    32'h2);
        chk("t3_c5_hwdata", 32'(hwdata),    32'h77);
        tick();
        mid();
        chk("t3_c6_hwdata", 32'(hwdata), 32'h88);
        chk("t3_c6_htrans", 32'(htrans), 32'h0);
        tick();
        tick();

        // Two-cycle ERROR on 0x40, 0x41 parked then reissued
        cmd(1'b1, 1'b1, 8'h40, 8'hA0); push(8'h00, 1'b1);
        tick();
        cmd(1'b1, 1'b1, 8'h41, 8'hB1); push(8'h00, 1'b0);
        mid();
        chk("t4_c1_haddr", 32'(haddr), 32'h40);
        tick();
        cmd(1'b0, 1'b0, 8'h00, 8'h00);
        hresp  = 1'b1;
        hready = 1'b0;
        mid();
        chk("t4_c2_htrans", 32'(htrans), 32'h2);
        chk("t4_c2_haddr",  32'(haddr),  32'h41);
        chk("t4_c2_hwdata", 32'(hwdata), 32'hA0);
        tick();
        hready = 1'b1;
        mid();
        chk("t4_c3_htrans", 32'(htrans),    32'h0);
        chk("t4_c3_ready",  32'(cmd_ready), 32'h0);
        chk("t4_c3_rspv",   32'(rsp_valid), 32'h0);
        tick();
        hresp = 1'b0;
        mid();
        chk("t4_c4_rspv",   32'(rsp_valid), 32'h1);
        chk("t4_c4_rsperr", 32'(rsp_err),   32'h1);
        chk("t4_c4_htrans", 32'(htrans),    32'h2);
        chk("t4_c4_haddr",  32'(haddr),     32'h41);
        tick();
        mid();
        chk("t4_c5_hwdata", 32'(hwdata), 32'hB1);
        chk("t4_c5_htrans", 32'(htrans), 32'h0);
        tick();
        mid();
        chk("t4_c6_rspv", 32'(rsp_valid), 32'h1);
        tick();
        tick();

        // Reset asserted during a data phase: no response may follow
        cmd(1'b1, 1'b1, 8'h05, 8'h3C);
        tick();
        cmd(1'b0, 1'b0, 8'h00, 8'h00);
        mid();
        chk("t5_c1_haddr", 32'(haddr), 32'h05);
        tick();
        hreset_n = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        tick();
        tick();
        mid();
        chk("t5_inreset_rspv", 32'(rsp_valid), 32'h0);
        tick();
        hreset_n = 1'b1;
        single_write("t5_after");

        mid();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
